// File: rtl/datapath_registers_if.sv
// Control, memory and ALU signals of the processor datapath register block.
// The DUT takes the slave modport; the sequencer/bench takes the master modport.
interface datapath_registers_if;
    logic       processor_enable;
    logic       PC_write_enable;
    logic [1:0] PC_mux_select;
    logic       ACC_write_enable;
    logic [1:0] ACC_mux_select;
    logic       IR_load_enable;
    logic       ALU_inputB_mux_select;
    logic [1:0] Memory_address_mux_select;
    logic [7:0] mem_rdata;
    logic [7:0] alu_result;
    logic       scan_enable;
    logic       scan_in;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] instruction;
    logic       ZF;
    logic [4:0] PC;
    logic       scan_out;

    modport slave (
        input  processor_enable, PC_write_enable, PC_mux_select,
        input  ACC_write_enable, ACC_mux_select, IR_load_enable,
        input  ALU_inputB_mux_select, Memory_address_mux_select,
        input  mem_rdata, alu_result, scan_enable, scan_in,
        output mem_addr, mem_wdata, alu_a, alu_b, instruction, ZF, PC, scan_out
    );

    modport master (
        output processor_enable, PC_write_enable, PC_mux_select,
        output ACC_write_enable, ACC_mux_select, IR_load_enable,
        output ALU_inputB_mux_select, Memory_address_mux_select,
        output mem_rdata, alu_result, scan_enable, scan_in,
        input  mem_addr, mem_wdata, alu_a, alu_b, instruction, ZF, PC, scan_out
    );
endinterface

// File: rtl/datapath_registers.sv
// PC (5b), ACC (8b) and IR (8b) registers with their input muxes, combinational
// datapath outputs and a 21-bit scan chain PC[4] -> ... -> IR[0].
module datapath_registers (
    input  logic                  clk,
    input  logic                  rst,
    datapath_registers_if.slave   bus
);
    logic [4:0]  r_pc;
    logic [7:0]  r_acc;
    logic [7:0]  r_ir;

    logic [4:0]  w_pc_next;
    logic [7:0]  w_acc_next;
    logic [20:0] w_chain;
    logic [20:0] w_scan_next;

    // PC arithmetic wraps naturally in 5 bits.
    always_comb begin
        w_pc_next = r_pc;
        unique case (bus.PC_mux_select)
            2'b00: w_pc_next = r_pc + 5'd1;
            2'b01: w_pc_next = r_acc[4:0];
            2'b10: w_pc_next = r_pc - 5'd3;
            2'b11: w_pc_next = r_pc + 5'd2;
            default: w_pc_next = r_pc;
        endcase
    end

    always_comb begin
        w_acc_next = r_acc;
        unique case (bus.ACC_mux_select)
            2'b00: w_acc_next = bus.alu_result;
            2'b01: w_acc_next = bus.mem_rdata;
            2'b10: w_acc_next = {3'b000, r_pc};
            2'b11: w_acc_next = r_acc;
            default: w_acc_next = r_acc;
        endcase
    end

    assign w_chain          = {r_pc, r_acc, r_ir};
    assign w_scan_next[20]  = bus.scan_in;
    generate
        for (genvar gi = 0; gi < 20; gi++) begin : g_scan
            assign w_scan_next[gi] = w_chain[gi + 1];
        end
    endgenerate

    // Scan dominates functional writes; all muxes above see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= 5'd0;
            r_acc <= 8'd0;
            r_ir  <= 8'd0;
        end else if (bus.scan_enable) begin
            {r_pc, r_acc, r_ir} <= w_scan_next;
        end else if (bus.processor_enable) begin
            if (bus.PC_write_enable)  r_pc  <= w_pc_next;
            if (bus.ACC_write_enable) r_acc <= w_acc_next;
            if (bus.IR_load_enable)   r_ir  <= bus.mem_rdata;
        end
    end

    always_comb begin
        bus.mem_addr = 5'd0;
        unique case (bus.Memory_address_mux_select)
            2'b00: bus.mem_addr = r_ir[4:0];
            2'b01: bus.mem_addr = r_acc[4:0];
            2'b10: bus.mem_addr = r_pc;
            2'b11: bus.mem_addr = 5'd0;
            default: bus.mem_addr = 5'd0;
        endcase
    end

    assign bus.mem_wdata   = r_acc;
    assign bus.alu_a       = r_acc;
    assign bus.alu_b       = bus.ALU_inputB_mux_select ? {4'b0000, r_ir[3:0]} : bus.mem_rdata;
    assign bus.instruction = r_ir;
    assign bus.ZF          = (r_acc == 8'h00);
    assign bus.PC          = r_pc;
    assign bus.scan_out    = w_chain[0];
endmodule

// File: doc/datapath_registers.md
DATAPATH_REGISTERS -- requirements
Module: datapath_registers

Interface
REQ-001 SHALL have no parameters; widths fixed (PC 5 bits, ACC 8 bits, IR 8 bits).
REQ-002 clk  in  1  single clock; all registers update on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 processor_enable  in  1  gates all functional register updates.
REQ-005 PC_write_enable  in  1  load PC from PC mux.
REQ-006 PC_mux_select  in  2  00 PC+1, 01 ACC[4:0], 10 PC-3, 11 PC+2.
REQ-007 ACC_write_enable  in  1  load ACC from ACC mux.
REQ-008 ACC_mux_select  in  2  00 alu_result, 01 mem_rdata, 10 {3'b000,PC}, 11 hold.
REQ-009 IR_load_enable  in  1  load IR from mem_rdata.
REQ-010 ALU_inputB_mux_select  in  1  0 mem_rdata, 1 immediate.
REQ-011 Memory_address_mux_select  in  2  00 IR[4:0], 01 ACC[4:0], 10 PC, 11 5'd0.
REQ-012 mem_rdata  in  8  memory read data (combinational from mem_addr).
REQ-013 alu_result  in  8  ALU output.
REQ-014 scan_enable  in  1  scan shift mode.
REQ-015 scan_in  in  1  scan chain serial input.
REQ-016 mem_addr  out  5  memory address per REQ-011.
REQ-017 mem_wdata  out  8  equals ACC.
REQ-018 alu_a  out  8  equals ACC.
REQ-019 alu_b  out  8  mem_rdata or {4'b0000,IR[3:0]} per REQ-010.
REQ-020 instruction  out  8  equals IR.
REQ-021 ZF  out  1  1 when ACC == 8'h00.
REQ-022 PC  out  5  current PC.
REQ-023 scan_out  out  1  equals IR[0].

Function
REQ-024 All outputs other than the PC, ACC and IR registers SHALL be combinational; there is no added latency.
REQ-025 PC arithmetic SHALL be modulo 32: 31+1 -> 0, 30+2 -> 0, 31+2 -> 1, 2-3 -> 31, 0-3 -> 29.
REQ-026 With scan_enable=0 and processor_enable=1, each enabled register SHALL load its mux value at the clock edge; disabled registers SHALL hold.
REQ-027 With processor_enable=0 and scan_enable=0, PC, ACC and IR SHALL hold regardless of the write enables.
REQ-028 When PC, ACC and IR are written in the same cycle, every mux SHALL use pre-edge values. Example: for JSR (PC_mux=01, ACC_mux=10), PC and ACC[4:0] swap.
REQ-029 ACC_write_enable=1 with ACC_mux_select=11 SHALL leave ACC unchanged.
REQ-030 With scan_enable=1, all 21 bits SHALL shift one position per clock, independent of processor_enable, and all functional writes SHALL be suppressed.
REQ-031 Scan chain order SHALL be: scan_in -> PC[4] -> ... -> PC[0] -> ACC[7] -> ... -> ACC[0] -> IR[7] -> ... -> IR[0] -> scan_out.
REQ-032 ZF and mem_addr SHALL track ACC and PC during scan shifting.

Reset
REQ-033 While rst=1, and immediately on assertion without waiting for a clock, the block SHALL hold PC=0, ACC=0 and IR=0; therefore ZF=1, mem_wdata=0 and scan_out=0.
REQ-034 Deasserting rst mid-scan or mid-instruction SHALL resume from the all-zero state; no partial state is retained.

Verification
REQ-035 Apply reset, then 33 cycles with PC_write_enable=1 and PC_mux=00 -> PC sequence 0,1,...,31,0,1.
REQ-036 With PC=2, issue PC_mux=10 -> PC=31; then issue PC_mux=11 -> PC=1.
REQ-037 With ACC=8'h1A and PC=5, issue PC_mux=01 and ACC_mux=10 in one cycle -> PC=26 and ACC=8'h05.
REQ-038 Load IR=8'hE7 and set ALU_inputB_mux_select=1 -> alu_b=8'h07; set Memory_address_mux_select=00 -> mem_addr=7.
REQ-039 Run 21 scan clocks with pattern 21'h1ABCDE, with write enables asserted throughout -> PC=5'h1A, ACC=8'hBC, IR=8'hDE, with no functional write taking effect; 21 further clocks return the pattern on scan_out.
REQ-040 Assert rst asynchronously mid-cycle while ACC=8'h00 is not the current value -> ACC=0 and ZF=1 before the next clock edge.
